scan_test_ctrl: RTL

//  On-chip scan test controller that sits directly upstream of a scan-inserted

---
 rtl/scan_test_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_ctrl
// Purpose  : Single-chain scan test sequencer (load / capture / unload) with
//            response compare; optional 16-bit MISR under SCAN_MISR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 2,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 TM,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [15:0]          signature
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_UNLOAD  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] captured_q, captured_d;
    logic                 pass_q, pass_d;
    logic                 w_last;
    logic [CHAIN_LEN-1:0] w_cap_sample;

    assign w_last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    // Unload cycle k writes SO into bit N-1-k; other bits keep their value.
    always_comb begin
        w_cap_sample = captured_q;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (CNT_W'(CHAIN_LEN - 1 - i) == cnt_q) begin
                w_cap_sample[i] = SO;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        exp_d      = exp_q;
        captured_d = captured_q;
        pass_d     = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    pat_d   = pattern;
                    exp_d   = expected;
                    pass_d  = 1'b0;
                end
            end
            S_LOAD: begin
                // MSB is always presented on SI, so shift toward the MSB.
                pat_d = pat_q << 1;
                if (w_last) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_UNLOAD;
            end
            S_UNLOAD: begin
                captured_d = w_cap_sample;
                if (w_last) begin
                    state_d = S_DONE;
                    pass_d  = (w_cap_sample == exp_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            exp_q      <= '0;
            captured_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            exp_q      <= exp_d;
            captured_q <= captured_d;
            pass_q     <= pass_d;
        end
    end

    assign TM       = (state_q == S_LOAD) || (state_q == S_UNLOAD);
    assign SI       = (state_q == S_LOAD) && pat_q[CHAIN_LEN-1];
    assign busy     = (state_q == S_LOAD) || (state_q == S_CAPTURE) || (state_q == S_UNLOAD);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign captured = captured_q;

`ifdef SCAN_MISR_EN
    logic [15:0] sig_q;

    // Accumulates across tests; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else if (state_q == S_UNLOAD) begin
            sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {15'b0, SO};
        end
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

endmodule
`default_nettype wire
